// File: rtl/io_periph_pkg.sv
// Shared constants and types for the memory-mapped IO peripheral block.
package io_periph_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [ADDR_W-1:0] OFF_UART_DATA = 16'h0000;
    localparam logic [ADDR_W-1:0] OFF_UART_STAT = 16'h0004;
    localparam logic [ADDR_W-1:0] OFF_TIMER_CNT = 16'h0008;
    localparam logic [ADDR_W-1:0] OFF_TIMER_CMP = 16'h000C;
    localparam logic [ADDR_W-1:0] OFF_IRQ_STAT  = 16'h0010;
    localparam logic [ADDR_W-1:0] OFF_CYCLE     = 16'h0014;

    localparam int unsigned STAT_OVF_BIT = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef struct packed {
        logic [26:0] rsvd;
        logic        ovf;
        logic        busy;
        logic        empty;
        logic        full;
        logic        zero;
    } uart_stat_t;

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 bit serialiser: accepts one byte while idle and shifts it out LSB first.
module uart_tx_ser
    import io_periph_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] data,
    input  logic              valid,
    output logic              ready_c,
    output logic              line
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    tx_state_t         state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [2:0]        bit_idx, bit_idx_d;
    logic [BYTE_W-1:0] sh, sh_d;
    logic              line_d;
    logic              baud_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            line    <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            sh      <= sh_d;
            line    <= line_d;
        end
    end

    assign baud_done = (cnt == CNT_LAST);
    assign ready_c   = (state == TX_IDLE);

    // Line value is registered alongside the state so each bit lasts exactly BAUD_DIV clocks.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        sh_d      = sh;
        line_d    = line;
        case (state)
            TX_IDLE: begin
                line_d = 1'b1;
                if (valid) begin
                    state_d = TX_START;
                    sh_d    = data;
                    cnt_d   = '0;
                    line_d  = 1'b0;
                end
            end
            TX_START: begin
                if (baud_done) begin
                    state_d   = TX_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    line_d    = sh[0];
                    sh_d      = {1'b0, sh[BYTE_W-1:1]};
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = TX_STOP;
                        line_d  = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        line_d    = sh[0];
                        sh_d      = {1'b0, sh[BYTE_W-1:1]};
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (baud_done) begin
                    state_d = TX_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/io_periph.sv
// IO peripheral: UART TX FIFO, free-running timer with compare interrupt, cycle counter.
module io_periph
    import io_periph_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              io_r,
    input  logic              io_w,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              uart_tx,
    output logic              irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_empty, fifo_full;
    logic              tx_ready;
    logic              push, pop, drop;

    logic              ovf, pending;
    logic [DATA_W-1:0] timer_cnt, timer_cmp, cycle_cnt;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_addr_bits;
    uart_stat_t        stat_c;

    assign word_addr        = {io_addr[ADDR_W-1:2], 2'b00};
    assign unused_addr_bits = ^io_addr[1:0];

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
    assign pop        = tx_ready && !fifo_empty;
    // Full is judged before any same-cycle pop, so a write into a full FIFO always drops.
    assign push       = io_w && (word_addr == OFF_UART_DATA) && !fifo_full;
    assign drop       = io_w && (word_addr == OFF_UART_DATA) && fifo_full;
    assign irq        = pending;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= io_wdata[BYTE_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Status flags, timer and cycle counter; a compare match beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf       <= 1'b0;
            pending   <= 1'b0;
            timer_cnt <= '0;
            timer_cmp <= '1;
            cycle_cnt <= '0;
        end else begin
            if (drop)
                ovf <= 1'b1;
            else if (io_w && (word_addr == OFF_UART_STAT) && io_wdata[STAT_OVF_BIT])
                ovf <= 1'b0;

            if (io_w && (word_addr == OFF_TIMER_CNT))
                timer_cnt <= io_wdata;
            else
                timer_cnt <= timer_cnt + DATA_W'(1);

            if (io_w && (word_addr == OFF_TIMER_CMP))
                timer_cmp <= io_wdata;

            if (timer_cnt == timer_cmp)
                pending <= 1'b1;
            else if (io_w && (word_addr == OFF_IRQ_STAT) && io_wdata[0])
                pending <= 1'b0;

            cycle_cnt <= cycle_cnt + DATA_W'(1);
        end
    end

    always_comb begin
        stat_c       = '0;
        stat_c.ovf   = ovf;
        stat_c.busy  = !tx_ready;
        stat_c.empty = fifo_empty;
        stat_c.full  = fifo_full;
    end

    // Zero-latency read mux.
    always_comb begin
        io_rdata = '0;
        if (io_r) begin
            case (word_addr)
                OFF_UART_STAT: io_rdata = stat_c;
                OFF_TIMER_CNT: io_rdata = timer_cnt;
                OFF_TIMER_CMP: io_rdata = timer_cmp;
                OFF_IRQ_STAT:  io_rdata = DATA_W'(pending);
                OFF_CYCLE:     io_rdata = cycle_cnt;
                default:       io_rdata = '0;
            endcase
        end
    end

    uart_tx_ser #(
        .BAUD_DIV(BAUD_DIV)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (fifo_mem[rd_ptr]),
        .valid   (!fifo_empty),
        .ready_c (tx_ready),
        .line    (uart_tx)
    );

endmodule

// File: doc/io_periph.md
IO_PERIPH -- requirements
Module: io_periph

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 16, meaning clocks per UART bit (legal range >=2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries (power of two).
REQ-003 SHALL have port clk  in  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port io_r  in  1  read strobe from the memory stage.
REQ-006 SHALL have port io_w  in  1  write strobe from the memory stage.
REQ-007 SHALL have port io_addr  in  16  byte address; bits [1:0] ignored.
REQ-008 SHALL have port io_wdata  in  32  write data.
REQ-009 SHALL have port io_rdata  out  32  read data.
REQ-010 SHALL have port uart_tx  out  1  serial line, 8N1, idle high.
REQ-011 SHALL have port irq  out  1  timer interrupt request, level.

Function
REQ-012 SHALL drive io_rdata combinationally from io_addr and current register state in the same cycle io_r is high (zero-latency read), and SHALL drive 0 when io_r is low.
REQ-013 SHALL commit writes at the rising edge ending the cycle io_w is high; reads SHALL have no side effects.
REQ-014 SHALL decode the register map: 0x00 UART_DATA (W: push io_wdata[7:0]; R: 0); 0x04 UART_STAT (R: {27'b0, ovf, busy, empty, full, 1'b0}; W: bit4=1 clears ovf); 0x08 TIMER_CNT (R/W); 0x0C TIMER_CMP (R/W); 0x10 IRQ_STAT (R: bit0 pending; W: bit0=1 clears); 0x14 CYCLE (R only).
REQ-015 SHALL return 0 for reads of unmapped addresses and ignore writes to them and to CYCLE.
REQ-016 SHALL, on a UART_DATA write with the FIFO full, drop the byte and set sticky ovf, even if a pop occurs the same cycle.
REQ-017 SHALL pop the FIFO head into the transmitter when the transmitter is IDLE and the FIFO is non-empty, and SHALL leave IDLE on the following edge.
REQ-018 SHALL run the transmitter FSM IDLE -> START (line 0, BAUD_DIV clocks) -> DATA (8 bits LSB first, BAUD_DIV clocks each) -> STOP (line 1, BAUD_DIV clocks) -> IDLE.
REQ-019 SHALL report busy=1 whenever the FSM is not IDLE.
REQ-020 SHALL increment TIMER_CNT by 1 every cycle, wrapping 0xFFFFFFFF to 0; a TIMER_CNT write SHALL load io_wdata instead of incrementing that cycle.
REQ-021 SHALL set pending on the edge following a cycle in which TIMER_CNT equals TIMER_CMP (pre-write value); set SHALL win over a simultaneous clear.
REQ-022 SHALL drive irq = pending.
REQ-023 SHALL increment CYCLE every cycle, wrapping, never writable.
REQ-024 SHALL perform the write, and still drive valid read data, if io_r and io_w are both high.

Reset
REQ-025 SHALL, while rst_n is low, clear FIFO (empty=1, full=0), ovf, pending, TIMER_CNT, CYCLE, and set TIMER_CMP to 0xFFFFFFFF, FSM to IDLE, uart_tx=1, irq=0.
REQ-026 SHALL abort any in-flight character on reset assertion with uart_tx returning high immediately.

Structure
REQ-027 SHALL place register offset constants and the transmitter state enum in package io_periph_pkg.
REQ-028 SHALL implement the bit-level serialiser as sub-module uart_tx_ser (byte/valid in, ready and line out); FIFO and registers stay in io_periph.

Verification
REQ-029 Write 0x55 to 0x00 with BAUD_DIV=16 -> uart_tx low 16 clocks, then 1,0,1,0,1,0,1,0 for 16 clocks each, high 16 clocks; busy=1 throughout.
REQ-030 Nine UART_DATA writes back-to-back while idle -> 8 bytes transmitted in order, one byte accepted by the transmitter, at most one drop; ovf reads 1 if dropped; write 0x10 to 0x04 -> ovf 0.
REQ-031 Write TIMER_CMP=0x10, TIMER_CNT=0x0C -> irq rises 5 edges after the CNT write; write 1 to 0x10 -> irq 0; CNT wraps past 0xFFFFFFFF to 0.
REQ-032 Clear IRQ_STAT in the same cycle a match occurs -> pending stays 1.
REQ-033 Read 0x18 and 0x14 with io_r=1 -> 0 and current CYCLE same cycle; write to 0x14 -> CYCLE unchanged.
REQ-034 Assert rst_n=0 mid-DATA bit -> uart_tx=1, FIFO empty, irq=0 before the next clk edge.
